// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared register map, CTRL layout and FSM states for the DMA engine
package dma_pkg;

    localparam logic [1:0] REG_SRC   = 2'd0;
    localparam logic [1:0] REG_DST   = 2'd1;
    localparam logic [1:0] REG_COUNT = 2'd2;
    localparam logic [1:0] REG_CTRL  = 2'd3;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_W32    = 1;
    localparam int CTRL_DST_LO = 2;
    localparam int CTRL_SRC_LO = 4;
    localparam int CTRL_START  = 6;
    localparam int CTRL_RPT    = 7;
    localparam int CTRL_IRQ_EN = 8;
    localparam int CTRL_W      = 9;

    localparam logic [1:0] ADDRCTL_INC    = 2'd0;
    localparam logic [1:0] ADDRCTL_DEC    = 2'd1;
    localparam logic [1:0] ADDRCTL_FIXED  = 2'd2;
    localparam logic [1:0] ADDRCTL_RELOAD = 2'd3;

    localparam logic [1:0] WIDTH_HALF = 2'd1;
    localparam logic [1:0] WIDTH_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_DONE
    } state_t;

    function automatic logic [1:0] width_code(input logic w32);
        return w32 ? WIDTH_WORD : WIDTH_HALF;
    endfunction

endpackage

// File: rtl/dma_channel.sv
// rtl/dma_channel.sv - one DMA channel: shadow/working regs, pending flag, address stepping
module dma_channel
    import dma_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr_en,
    input  logic [1:0]        reg_sel,
    input  logic [31:0]       reg_wdata,
    input  logic              trig,
    input  logic              unit_done,
    input  logic              done,
    output logic              pending,
    output logic              enable,
    output logic              width32,
    output logic              irq_en,
    output logic              last,
    output logic [ADDR_W-1:0] src_addr,
    output logic [ADDR_W-1:0] dst_addr
);

    logic [ADDR_W-1:0] sh_src, sh_dst, src, dst, next_src, next_dst, delta;
    logic [CNT_W-1:0]  sh_cnt, cnt;
    logic [CTRL_W-1:0] ctrl;
    logic [1:0]        src_ctl, dst_ctl;
    logic              unused_wdata;

    assign unused_wdata = ^reg_wdata;
    assign enable  = ctrl[CTRL_EN];
    assign width32 = ctrl[CTRL_W32];
    assign irq_en  = ctrl[CTRL_IRQ_EN];
    assign src_ctl = ctrl[CTRL_SRC_LO +: 2];
    assign dst_ctl = ctrl[CTRL_DST_LO +: 2];
    assign last    = (cnt == CNT_W'(1));
    assign delta   = width32 ? ADDR_W'(4) : ADDR_W'(2);

    // Working addresses keep their low bits; alignment is applied only on the bus.
    assign src_addr = width32 ? {src[ADDR_W-1:2], 2'b00} : {src[ADDR_W-1:1], 1'b0};
    assign dst_addr = width32 ? {dst[ADDR_W-1:2], 2'b00} : {dst[ADDR_W-1:1], 1'b0};

    always_comb begin
        next_src = src;
        next_dst = dst;
        case (src_ctl)
            ADDRCTL_INC: next_src = src + delta;
            ADDRCTL_DEC: next_src = src - delta;
            default:     next_src = src;
        endcase
        case (dst_ctl)
            ADDRCTL_INC, ADDRCTL_RELOAD: next_dst = dst + delta;
            ADDRCTL_DEC:                 next_dst = dst - delta;
            default:                     next_dst = dst;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sh_src  <= '0;
            sh_dst  <= '0;
            sh_cnt  <= '0;
            src     <= '0;
            dst     <= '0;
            cnt     <= '0;
            ctrl    <= '0;
            pending <= 1'b0;
        end else begin
            if (unit_done) begin
                src <= next_src;
                dst <= next_dst;
                cnt <= cnt - CNT_W'(1);
            end
            if (trig && ctrl[CTRL_EN] && !pending)
                pending <= 1'b1;
            if (done) begin
                pending <= 1'b0;
                if (ctrl[CTRL_RPT] && ctrl[CTRL_START]) begin
                    cnt <= sh_cnt;
                    if (dst_ctl == ADDRCTL_RELOAD)
                        dst <= sh_dst;
                end else begin
                    ctrl[CTRL_EN] <= 1'b0;
                end
            end
            // Register writes come last so they win over a same-cycle DONE.
            if (wr_en) begin
                case (reg_sel)
                    REG_SRC:   sh_src <= reg_wdata[ADDR_W-1:0];
                    REG_DST:   sh_dst <= reg_wdata[ADDR_W-1:0];
                    REG_COUNT: sh_cnt <= reg_wdata[CNT_W-1:0];
                    default: begin
                        ctrl <= reg_wdata[CTRL_W-1:0];
                        if (reg_wdata[CTRL_EN] && !ctrl[CTRL_EN]) begin
                            src     <= sh_src;
                            dst     <= sh_dst;
                            cnt     <= sh_cnt;
                            pending <= !reg_wdata[CTRL_START];
                        end else if (!reg_wdata[CTRL_EN]) begin
                            pending <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/dma_engine.sv
// rtl/dma_engine.sv - multi-channel DMA bus master: priority arbiter, unit FSM, bus drivers
module dma_engine
    import dma_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       reg_wr,
    input  logic [$clog2(NUM_CH)-1:0]  reg_ch,
    input  logic [1:0]                 reg_sel,
    input  logic [31:0]                reg_wdata,
    input  logic [NUM_CH-1:0]          trig,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [31:0]                mem_wdata,
    input  logic [31:0]                mem_rdata,
    output logic [1:0]                 mem_width,
    output logic                       mem_read,
    output logic                       mem_write,
    input  logic                       mem_ok,
    output logic                       busy,
    output logic [NUM_CH-1:0]          irq
);

    localparam int CH_W = $clog2(NUM_CH);

    state_t            state;
    logic [CH_W-1:0]   cur, sel_ch;
    logic              sel_valid;
    logic [NUM_CH-1:0] ch_pending, ch_en, ch_w32, ch_irq_en, ch_last, ch_unit_done, ch_done;
    logic [ADDR_W-1:0] ch_src [NUM_CH];
    logic [ADDR_W-1:0] ch_dst [NUM_CH];
    logic [15:0]       rd_half;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch_unit_done[i] = (state == ST_WR) && mem_ok && (cur == CH_W'(i));
        assign ch_done[i]      = (state == ST_DONE) && (cur == CH_W'(i));

        dma_channel #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_ch (
            .clk       (clk),
            .rstn      (rstn),
            .wr_en     (reg_wr && (reg_ch == CH_W'(i))),
            .reg_sel   (reg_sel),
            .reg_wdata (reg_wdata),
            .trig      (trig[i]),
            .unit_done (ch_unit_done[i]),
            .done      (ch_done[i]),
            .pending   (ch_pending[i]),
            .enable    (ch_en[i]),
            .width32   (ch_w32[i]),
            .irq_en    (ch_irq_en[i]),
            .last      (ch_last[i]),
            .src_addr  (ch_src[i]),
            .dst_addr  (ch_dst[i])
        );
    end

    // Lowest index wins; scanning downwards leaves the smallest pending index selected.
    always_comb begin
        sel_valid = 1'b0;
        sel_ch    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_pending[i]) begin
                sel_valid = 1'b1;
                sel_ch    = CH_W'(i);
            end
        end
    end

    assign rd_half = mem_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            cur       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_width <= WIDTH_WORD;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            busy      <= 1'b0;
            irq       <= '0;
        end else begin
            irq <= '0;
            case (state)
                ST_IDLE: begin
                    busy <= sel_valid;
                    if (sel_valid) begin
                        state     <= ST_RD;
                        cur       <= sel_ch;
                        mem_read  <= 1'b1;
                        mem_addr  <= ch_src[sel_ch];
                        mem_width <= width_code(ch_w32[sel_ch]);
                    end
                end
                ST_RD: begin
                    if (mem_ok) begin
                        state     <= ST_WR;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b1;
                        mem_addr  <= ch_dst[cur];
                        mem_wdata <= (mem_width == WIDTH_WORD) ? mem_rdata : {rd_half, rd_half};
                    end
                end
                ST_WR: begin
                    if (mem_ok) begin
                        mem_write <= 1'b0;
                        // A channel disabled mid-unit ends here silently.
                        if (ch_en[cur] && ch_last[cur]) begin
                            state    <= ST_DONE;
                            irq[cur] <= ch_irq_en[cur];
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= |(ch_pending & ~(NUM_CH'(1) << cur));
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_engine.sv
// tb/tb_dma_engine.sv - self-checking bench for dma_engine against a transfer-list model
module tb_dma_engine;
    import dma_pkg::*;

    localparam int NUM_CH = 4;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 10;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        reg_wr = 1'b0;
    logic [1:0]  reg_ch = '0;
    logic [1:0]  reg_sel = '0;
    logic [31:0] reg_wdata = '0;
    logic [3:0]  trig = '0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_width;
    logic        mem_read, mem_write, mem_ok, busy;
    logic [3:0]  irq;
    logic        hold_ok = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  width;
        logic [31:0] data;
    } op_t;

    op_t         exp_rd[$];
    op_t         exp_wr[$];
    int          exp_irq[$];
    logic [31:0] rd_log[$];
    logic [31:0] wr_log[$];

    dma_engine #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .reg_wr    (reg_wr),
        .reg_ch    (reg_ch),
        .reg_sel   (reg_sel),
        .reg_wdata (reg_wdata),
        .trig      (trig),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_width (mem_width),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_ok    (mem_ok),
        .busy      (busy),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {~a[15:0], a[15:0] ^ 16'h5A3C};
    endfunction

    assign mem_ok    = (mem_read | mem_write) & ~hold_ok;
    assign mem_rdata = mem_fn(mem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected bus traffic of n units from the programming rules alone.
    task automatic plan(input int ch, input logic [31:0] src, input logic [31:0] dst, input int n,
                        input bit w32, input int sctl, input int dctl, input bit irq_exp);
        logic [31:0] s, d, sa, da, v, step;
        op_t o;
        s = src;
        d = dst;
        step = w32 ? 32'd4 : 32'd2;
        for (int k = 0; k < n; k++) begin
            sa = w32 ? {s[31:2], 2'b00} : {s[31:1], 1'b0};
            da = w32 ? {d[31:2], 2'b00} : {d[31:1], 1'b0};
            v = mem_fn(sa);
            o.addr = sa; o.width = w32 ? 2'd2 : 2'd1; o.data = '0;
            exp_rd.push_back(o);
            o.addr = da;
            o.data = w32 ? v : (sa[1] ? {v[31:16], v[31:16]} : {v[15:0], v[15:0]});
            exp_wr.push_back(o);
            if (sctl == 0) s = s + step; else if (sctl == 1) s = s - step;
            if (dctl == 0 || dctl == 3) d = d + step; else if (dctl == 1) d = d - step;
        end
        if (irq_exp) exp_irq.push_back(ch);
    endtask

    always @(negedge clk) begin : compare
        op_t e;
        if (rstn) begin
            if (mem_read && mem_ok) begin
                rd_log.push_back(mem_addr);
                if (exp_rd.size() == 0) chk("rd_expected", 32'(exp_rd.size()), 32'd1);
                else begin
                    e = exp_rd.pop_front();
                    chk("rd_addr", mem_addr, e.addr);
                    chk("rd_width", 32'(mem_width), 32'(e.width));
                end
            end
            if (mem_write && mem_ok) begin
                wr_log.push_back(mem_addr);
                if (exp_wr.size() == 0) chk("wr_expected", 32'(exp_wr.size()), 32'd1);
                else begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", mem_addr, e.addr);
                    chk("wr_width", 32'(mem_width), 32'(e.width));
                    chk("wr_data", mem_wdata, e.data);
                end
            end
            if (irq != 4'b0) begin
                if (exp_irq.size() == 0) chk("irq_unexpected", 32'(irq), 32'd0);
                else chk("irq_order", 32'(irq), 32'd1 << exp_irq.pop_front());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr(input int ch, input logic [1:0] sel, input logic [31:0] d);
        reg_wr = 1'b1; reg_ch = 2'(ch); reg_sel = sel; reg_wdata = d;
        cyc(1);
        reg_wr = 1'b0;
    endtask

    task automatic cfg(input int ch, input logic [31:0] s, input logic [31:0] d, input logic [31:0] c);
        wr(ch, REG_SRC, s);
        wr(ch, REG_DST, d);
        wr(ch, REG_COUNT, c);
    endtask

    task automatic pulse(input int ch);
        trig[ch] = 1'b1;
        cyc(1);
        trig = '0;
    endtask

    task automatic wait_irq(input int ch, input int max, output int n);
        n = 0;
        while (!irq[ch] && n < max) begin cyc(1); n++; end
        chk($sformatf("irq%0d_seen", ch), 32'(irq[ch]), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 200) begin cyc(1); n++; end
        chk(name, 32'(busy), 32'd0);
        chk({name, "_model_drained"}, 32'(exp_rd.size() + exp_wr.size() + exp_irq.size()), 32'd0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n, base, wbase;
        cyc(3);
        chk("rst_read", 32'(mem_read), 0);
        chk("rst_write", 32'(mem_write), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_width", 32'(mem_width), 2);
        rstn = 1'b1;
        cyc(2);

        // Word copy, inc/inc, immediate start
        base = rd_log.size();
        cfg(0, 32'h100, 32'h200, 4);
        plan(0, 32'h100, 32'h200, 4, 1, 0, 0, 1);
        wr(0, REG_CTRL, 32'h103);
        chk("t1_busy_pre", 32'(busy), 0);
        wait_irq(0, 40, n);
        chk("t1_irq_latency", n, 12);
        chk("t1_busy_at_irq", 32'(busy), 1);
        cyc(1);
        chk("t1_busy_fall", 32'(busy), 0);
        chk("t1_rd_first", rd_log[base], 32'h100);
        chk("t1_rd_last", rd_log[base+3], 32'h10C);
        chk("t1_wr_last", wr_log[base+3], 32'h20C);
        wait_idle("t1_idle");

        // Halfword, src dec, dst fixed, then an unaligned source
        base = rd_log.size();
        cfg(1, 32'h302, 32'h400, 3);
        plan(1, 32'h302, 32'h400, 3, 0, 1, 2, 1);
        wr(1, REG_CTRL, 32'h119);
        wait_irq(1, 40, n);
        wait_idle("t2_idle");
        chk("t2_rd0", rd_log[base], 32'h302);
        chk("t2_rd1", rd_log[base+1], 32'h300);
        chk("t2_rd2", rd_log[base+2], 32'h2FE);
        chk("t2_wr2", wr_log[base+2], 32'h400);
        cfg(1, 32'h303, 32'h400, 1);
        plan(1, 32'h303, 32'h400, 1, 0, 1, 2, 1);
        wr(1, REG_CTRL, 32'h119);
        wait_irq(1, 40, n);
        wait_idle("t2u_idle");
        chk("t2_unaligned", rd_log[rd_log.size()-1], 32'h302);

        // Preemption: ch0 triggered during ch3's second unit
        base = rd_log.size();
        wbase = wr_log.size();
        cfg(0, 32'h3000, 32'h4000, 2);
        wr(0, REG_CTRL, 32'h143);
        cfg(3, 32'h1000, 32'h2000, 8);
        plan(3, 32'h1000, 32'h2000, 2, 1, 0, 0, 0);
        plan(0, 32'h3000, 32'h4000, 2, 1, 0, 0, 1);
        plan(3, 32'h1008, 32'h2008, 6, 1, 0, 0, 1);
        wr(3, REG_CTRL, 32'h103);
        n = 0;
        while (!(mem_write && wr_log.size() == wbase + 1) && n < 50) begin cyc(1); n++; end
        chk("t3_second_wr", 32'(wr_log.size()), 32'(wbase + 1));
        pulse(0);
        wait_irq(0, 40, n);
        cyc(1);
        wait_irq(3, 60, n);
        wait_idle("t3_idle");
        chk("t3_ch0_rd", rd_log[base+2], 32'h3000);
        chk("t3_ch3_resume", rd_log[base+4], 32'h1008);

        // Trigger mode with repeat and dst reload
        base = rd_log.size();
        cfg(2, 32'h5000, 32'h6000, 2);
        wr(2, REG_CTRL, 32'h1CF);
        cyc(10);
        chk("t4_wait_busy", 32'(busy), 0);
        chk("t4_wait_quiet", 32'(rd_log.size()), 32'(base));
        plan(2, 32'h5000, 32'h6000, 2, 1, 0, 3, 1);
        plan(2, 32'h5008, 32'h6000, 2, 1, 0, 3, 1);
        pulse(2);
        cyc(2);
        pulse(2);
        wait_irq(2, 40, n);
        cyc(1);
        pulse(2);
        wait_irq(2, 40, n);
        wait_idle("t4_idle");
        chk("t4_wr_reload0", wr_log[wr_log.size()-2], 32'h6000);
        chk("t4_wr_reload1", wr_log[wr_log.size()-1], 32'h6004);
        wr(2, REG_CTRL, 32'h0);

        // Stalled read keeps the request stable
        cfg(1, 32'h7000, 32'h7100, 1);
        plan(1, 32'h7000, 32'h7100, 1, 1, 0, 0, 1);
        hold_ok = 1'b1;
        wr(1, REG_CTRL, 32'h103);
        n = 0;
        while (!mem_read && n < 10) begin cyc(1); n++; end
        for (int k = 0; k < 5; k++) begin
            chk("t5_stall_read", 32'(mem_read), 1);
            chk("t5_stall_addr", mem_addr, 32'h7000);
            cyc(1);
        end
        hold_ok = 1'b0;
        wait_irq(1, 20, n);
        wait_idle("t5_idle");

        // Reset in the middle of a write
        cfg(1, 32'h8000, 32'h8100, 4);
        plan(1, 32'h8000, 32'h8100, 4, 1, 0, 0, 1);
        wr(1, REG_CTRL, 32'h103);
        n = 0;
        while (!mem_write && n < 10) begin cyc(1); n++; end
        hold_ok = 1'b1;
        cyc(2);
        rstn = 1'b0;
        cyc(1);
        chk("t6_read", 32'(mem_read), 0);
        chk("t6_write", 32'(mem_write), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_irq", 32'(irq), 0);
        chk("t6_addr", mem_addr, 0);
        chk("t6_wdata", mem_wdata, 0);
        chk("t6_width", 32'(mem_width), 2);
        rstn = 1'b1;
        hold_ok = 1'b0;
        exp_rd.delete();
        exp_wr.delete();
        exp_irq.delete();
        base = rd_log.size();
        cyc(10);
        chk("t6_no_resume", 32'(rd_log.size()), 32'(base));
        wait_idle("t6_idle");

        // COUNT=0 runs 2^CNT_W halfword units, then an abort without irq
        cfg(0, 32'h9002, 32'h9100, 0);
        plan(0, 32'h9002, 32'h9100, 1 << CNT_W, 0, 2, 2, 1);
        wr(0, REG_CTRL, 32'h129);
        wait_irq(0, 3 * (1 << CNT_W) + 20, n);
        chk("t7_full_cycles", n, 3 * (1 << CNT_W));
        wait_idle("t7_idle");
        wbase = wr_log.size();
        plan(0, 32'h9002, 32'h9100, 6, 0, 2, 2, 0);
        wr(0, REG_CTRL, 32'h129);
        n = 0;
        while (!(mem_read && wr_log.size() == wbase + 5) && n < 50) begin cyc(1); n++; end
        wr(0, REG_CTRL, 32'h0);
        cyc(20);
        chk("t7_abort_units", 32'(wr_log.size()), 32'(wbase + 6));
        wait_idle("t7_abort_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
